tft_spi_tx: RTL

Byte-stream SPI serializer between the scene/init drivers and the TFT panel pins. It accepts `{tft_dc, tft_data}` bytes on the single-cycle `tft_transmit` strobe into a small FIFO, drives SPI mode 0 (MSB first) with a divided clock, and holds chip-select low across back-to-back bytes. `tft_busy` back-pressures the producer, which waits for `~tft_busy & ~tft_transmit` before each strobe.

---
 rtl/tft_spi_tx.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/tft_spi_tx.sv
// tft_spi_tx: byte FIFO feeding an SPI mode-0 (MSB first) serializer for a TFT panel.
// Chip select stays low across back-to-back bytes. After a lone byte it is released
// CLK_DIV cycles after the last falling SCLK edge.
module tft_spi_tx #(
  parameter int CLK_DIV = 2,
  parameter int DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tft_transmit,
  input  logic [7:0] tft_data,
  input  logic       tft_dc,
  output logic       tft_busy,
  output logic       spi_sclk,
  output logic       spi_mosi,
  output logic       spi_cs_n,
  output logic       spi_dc,
  output logic       overflow,
  output logic       idle
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, RELEASE} state_t;

  state_t           r_state, w_stateNext;
  logic [8:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr, r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;
  logic [7:0]       r_sr, w_srNext;
  logic [DIV_W-1:0] r_div, w_divNext, w_divCur;
  logic [2:0]       r_bitCnt, w_bitCntNext;
  logic             r_sclk, w_sclkNext;
  logic             r_csN, w_csNNext;
  logic             r_dc, w_dcNext;
  logic             w_push, w_pop, w_full, w_empty, w_tick;
  logic [8:0]       w_head;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = tft_transmit && !w_full;
  assign w_head  = r_mem[r_rdPtr];

  // FIFO storage has no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr] <= {tft_dc, tft_data};
  end

  // FIFO pointers and occupancy. A push that finds the FIFO full is dropped, and overflow latches until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (tft_transmit && w_full) r_overflow <= 1'b1;
    end
  end

  // Serializer state and registered SPI pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_sr     <= '0;
      r_div    <= '0;
      r_bitCnt <= '0;
      r_sclk   <= 1'b0;
      r_csN    <= 1'b1;
      r_dc     <= 1'b1;
    end else begin
      r_state  <= w_stateNext;
      r_sr     <= w_srNext;
      r_div    <= w_divNext;
      r_bitCnt <= w_bitCntNext;
      r_sclk   <= w_sclkNext;
      r_csN    <= w_csNNext;
      r_dc     <= w_dcNext;
    end
  end

  // Next-state logic. A pop loads the byte and pin values so that LOAD already shows cs low and bit 7.
  // The LOAD cycle is the first divider step, so the first SCLK rise lands CLK_DIV cycles after LOAD.
  // The first RELEASE cycle is where a queued byte is chained without raising cs.
  always_comb begin
    w_stateNext  = r_state;
    w_pop        = 1'b0;
    w_srNext     = r_sr;
    w_divNext    = r_div;
    w_bitCntNext = r_bitCnt;
    w_sclkNext   = r_sclk;
    w_csNNext    = r_csN;
    w_dcNext     = r_dc;
    w_divCur     = (r_state == LOAD) ? '0 : r_div;
    w_tick       = (w_divCur == DIV_LAST);
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_srNext    = w_head[7:0];
          w_dcNext    = w_head[8];
          w_csNNext   = 1'b0;
          w_stateNext = LOAD;
        end
      end
      LOAD, SHIFT: begin
        if (r_state == LOAD) w_bitCntNext = '0;
        w_stateNext = SHIFT;
        if (w_tick) begin
          w_divNext = '0;
          if (!r_sclk) begin
            w_sclkNext = 1'b1;
          end else begin
            w_sclkNext   = 1'b0;
            w_srNext     = {r_sr[6:0], 1'b0};
            w_bitCntNext = r_bitCnt + 3'd1;
            if (r_bitCnt == 3'd7) w_stateNext = RELEASE;
          end
        end else begin
          w_divNext = w_divCur + DIV_W'(1);
        end
      end
      RELEASE: begin
        if ((r_div == '0) && !w_empty) begin
          w_pop       = 1'b1;
          w_srNext    = w_head[7:0];
          w_dcNext    = w_head[8];
          w_stateNext = LOAD;
        end else if (r_div == DIV_LAST) begin
          w_divNext   = '0;
          w_csNNext   = 1'b1;
          w_stateNext = IDLE;
        end else begin
          w_divNext = r_div + DIV_W'(1);
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  assign spi_sclk = r_sclk;
  assign spi_mosi = r_sr[7];
  assign spi_cs_n = r_csN;
  assign spi_dc   = r_dc;
  assign tft_busy = w_full;
  assign overflow = r_overflow;
  assign idle     = w_empty && (r_state == IDLE) && r_csN;

endmodule
